// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if;
  logic        r0_req_in;
  logic        r0_we_in;
  logic [31:0] r0_addr_in;
  logic [31:0] r0_writedata_in;
  logic [1:0]  r0_size_in;
  logic        r0_gnt_out;
  logic        r0_rvalid_out;
  logic [31:0] r0_readdata_out;

  logic        r1_req_in;
  logic        r1_we_in;
  logic [31:0] r1_addr_in;
  logic [31:0] r1_writedata_in;
  logic [1:0]  r1_size_in;
  logic        r1_gnt_out;
  logic        r1_rvalid_out;
  logic [31:0] r1_readdata_out;

  logic [31:0] mem_addr_out;
  logic [31:0] mem_writedata_out;
  logic [1:0]  mem_size_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [31:0] mem_readdata_in;

  modport slave (
    input  r0_req_in, r0_we_in, r0_addr_in, r0_writedata_in, r0_size_in,
    output r0_gnt_out, r0_rvalid_out, r0_readdata_out,
    input  r1_req_in, r1_we_in, r1_addr_in, r1_writedata_in, r1_size_in,
    output r1_gnt_out, r1_rvalid_out, r1_readdata_out,
    output mem_addr_out, mem_writedata_out, mem_size_out, mem_re_out, mem_we_out,
    input  mem_readdata_in
  );

  modport master (
    output r0_req_in, r0_we_in, r0_addr_in, r0_writedata_in, r0_size_in,
    input  r0_gnt_out, r0_rvalid_out, r0_readdata_out,
    output r1_req_in, r1_we_in, r1_addr_in, r1_writedata_in, r1_size_in,
    input  r1_gnt_out, r1_rvalid_out, r1_readdata_out,
    input  mem_addr_out, mem_writedata_out, mem_size_out, mem_re_out, mem_we_out,
    output mem_readdata_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (r0 wins).
module dmem_arbiter #(
  parameter bit WRITE_ACK = 1'b1
) (
  input logic            clock,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        idx_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        any_req;
  logic        win_idx;
  logic        latch;

  assign any_req = bus.r0_req_in | bus.r1_req_in;
  assign latch   = (state_q == StIdle) && any_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie the requester that did not win last goes next.
  always_comb begin
    win_idx = bus.r1_req_in;
    if (bus.r0_req_in && bus.r1_req_in) begin
      win_idx = ~last_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (latch) begin
      last_q <= win_idx;
    end
  end
`else
  assign win_idx = ~bus.r0_req_in;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      idx_q   <= 1'b0;
    end else if (latch) begin
      idx_q   <= win_idx;
      we_q    <= win_idx ? bus.r1_we_in        : bus.r0_we_in;
      addr_q  <= win_idx ? bus.r1_addr_in      : bus.r0_addr_in;
      wdata_q <= win_idx ? bus.r1_writedata_in : bus.r0_writedata_in;
      size_q  <= win_idx ? bus.r1_size_in      : bus.r0_size_in;
    end
  end

  // Memory read is asynchronous, so its data is valid by the end of ACCESS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == StAccess && !we_q) begin
      if (idx_q) begin
        rdata1_q <= bus.mem_readdata_in;
      end else begin
        rdata0_q <= bus.mem_readdata_in;
      end
    end
  end

  always_comb begin
    bus.r0_gnt_out    = 1'b0;
    bus.r1_gnt_out    = 1'b0;
    bus.r0_rvalid_out = 1'b0;
    bus.r1_rvalid_out = 1'b0;
    bus.mem_re_out    = 1'b0;
    bus.mem_we_out    = 1'b0;
    unique case (state_q)
      StAccess: begin
        bus.mem_re_out = ~we_q;
        bus.mem_we_out = we_q;
        bus.r0_gnt_out = ~idx_q;
        bus.r1_gnt_out = idx_q;
      end
      StResp: begin
        bus.r0_rvalid_out = ~idx_q & (~we_q | WRITE_ACK);
        bus.r1_rvalid_out = idx_q & (~we_q | WRITE_ACK);
      end
      default: ;
    endcase
  end

  assign bus.mem_addr_out      = addr_q;
  assign bus.mem_writedata_out = wdata_q;
  assign bus.mem_size_out      = size_q;
  assign bus.r0_readdata_out   = rdata0_q;
  assign bus.r1_readdata_out   = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WRITE_ACK, default 1: when 1, rvalid pulses for writes as well as reads; when 0, it pulses for reads only.
REQ-002 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports rN_req_in  input  1  request from requester N, N=0 (core load/store) and N=1 (loader/DMA).
REQ-005 The block SHALL have ports rN_we_in  input  1  write when 1, read when 0.
REQ-006 The block SHALL have ports rN_addr_in  input  32  byte address.
REQ-007 The block SHALL have ports rN_writedata_in  input  32  write data.
REQ-008 The block SHALL have ports rN_size_in  input  2  access size, passed through unchanged.
REQ-009 The block SHALL have ports rN_gnt_out  output  1  grant pulse.
REQ-010 The block SHALL have ports rN_rvalid_out  output  1  completion pulse.
REQ-011 The block SHALL have ports rN_readdata_out  output  32  read data.
REQ-012 The block SHALL have ports mem_addr_out  output  32, mem_writedata_out  output  32 and mem_size_out  output  2, driving data memory.
REQ-013 The block SHALL have ports mem_re_out  output  1 and mem_we_out  output  1, data memory enables.
REQ-014 The block SHALL have port mem_readdata_in  input  32  asynchronous read data from data memory.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCESS, RESP with transitions IDLE->ACCESS (any req sampled), ACCESS->RESP (always), RESP->IDLE (always).
REQ-016 In IDLE, at a rising edge with any rN_req_in=1, the block SHALL select one winner and latch its we, addr, writedata, size and index.
REQ-017 In ACCESS, the block SHALL drive the latched fields on mem_*_out, assert exactly one of mem_re_out/mem_we_out for exactly that cycle, and assert rN_gnt_out of the winner only.
REQ-018 At the end of ACCESS on a read, the block SHALL capture mem_readdata_in into the winner's rN_readdata_out register.
REQ-019 In RESP, the block SHALL pulse the winner's rN_rvalid_out for one cycle (reads always; writes only if WRITE_ACK=1).
REQ-020 Latency: the block SHALL assert gnt 1 cycle and rvalid 2 cycles after the sampling edge; throughput SHALL be one access per 3 cycles.
REQ-021 Requests arriving while not in IDLE SHALL NOT be sampled; a requester SHALL hold req and fields until gnt, and the block SHALL drop nothing once latched even if req falls.
REQ-022 Outside ACCESS, mem_re_out and mem_we_out SHALL be 0; mem_addr/writedata/size SHALL hold their last latched values.
REQ-023 rN_readdata_out SHALL hold its value until the next read completion for that requester; writes SHALL NOT alter it.
REQ-024 Unmapped addresses SHALL be passed through unchanged; the memory returns 0 and the block SHALL report it as normal read data.

Reset
REQ-025 Reset assertion SHALL take effect immediately in any state, aborting any in-flight access and returning the FSM to IDLE.
REQ-026 During reset, all outputs SHALL be 0: gnt, rvalid, mem_re, mem_we, mem_addr, mem_writedata, mem_size, readdata.
REQ-027 Reset SHALL set the last-winner register to 1, so requester 0 wins the first tie.
REQ-028 The first request SHALL be sampled at the first rising edge after reset deassertion.

Configuration
REQ-029 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the block SHALL grant the requester that did not win last; a lone requester always wins.
REQ-030 Macro DMEM_ARB_ROUND_ROBIN_EN undefined: the block SHALL use fixed priority, requester 0 always beating requester 1; starvation of requester 1 is permitted and the last-winner register is unused.

Verification
REQ-031 Single read: r0 reads 0x10000004 holding 0xDEADBEEF -> r0_gnt 1 cycle later, r0_rvalid 2 cycles later, r0_readdata=0xDEADBEEF, mem_re high exactly 1 cycle.
REQ-032 Simultaneous requests, RR enabled, both held for 4 accesses -> grant order r0,r1,r0,r1, each 3 cycles apart.
REQ-033 Simultaneous requests, RR disabled, r0 held continuously -> r1_gnt never asserts across 10 accesses.
REQ-034 r1 writes 0x12345678 to 0x7ffffff0, then r0 reads the same address -> r0_readdata=0x12345678; r1_rvalid pulses only when WRITE_ACK=1; mem_we/mem_re never high together.
REQ-035 Reset asserted during ACCESS -> all outputs 0 immediately, no rvalid afterward, a new request after release completes normally with r0 winning the tie.
